// File: rtl/simple_comp_arbiter_if.sv
// Bundle between two requesters, the shared simple_comp datapath and the
// response consumer.
//   req0_* / req1_* : valid/ready request with 16-bit operand triple a, b, c
//   comp_a/b/c      : operands issued to the datapath, comp_d_in its result
//   rsp_*           : one-cycle response pulse (result + owning requester)
//   drain/drained   : stop-issue request and pipeline-empty indication
// Modports: master = requester/datapath side, slave = arbiter.
interface simple_comp_arbiter_if;
  localparam int unsigned DATA_W = 16;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req0_c;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [DATA_W-1:0] req1_c;
  logic              req1_ready;

  logic [DATA_W-1:0] comp_a;
  logic [DATA_W-1:0] comp_b;
  logic [DATA_W-1:0] comp_c;
  logic [DATA_W-1:0] comp_d_in;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  logic              drain;
  logic              drained;

  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_c,
    input  req1_ready,
    input  comp_a, comp_b, comp_c,
    output comp_d_in,
    input  rsp_valid, rsp_id, rsp_data,
    output drain,
    input  drained
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_c,
    output req1_ready,
    output comp_a, comp_b, comp_c,
    input  comp_d_in,
    output rsp_valid, rsp_id, rsp_data,
    input  drain,
    output drained
  );
endinterface

// File: rtl/simple_comp_arbiter.sv
// Two-requester arbiter in front of a shared, fixed-latency simple_comp
// datapath. Accepted operands are issued for one cycle on comp_a/b/c; a
// valid+ID tag follows the datapath latency and the result returns on
// rsp_* COMP_LAT+1 cycles after acceptance.
//   clock   : sole clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : simple_comp_arbiter_if.slave (requests, datapath, response,
//             drain/drained)
// Parameter COMP_LAT (1..8): cycles from comp_a/b/c to valid comp_d_in.
// Macro SIMPLE_COMP_ARB_RR_EN: round-robin arbitration on contention;
// when undefined, requester 0 has fixed priority.
module simple_comp_arbiter #(
  parameter int unsigned COMP_LAT = 2
) (
  input logic              clock,
  input logic              rst,
  simple_comp_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t              state;
  logic                grant0_c;
  logic                grant1_c;
  logic                pipe_empty_c;

  // Issue stage: tag for the operands currently on comp_a/b/c
  logic                iss_vld;
  logic                iss_id;

  // Tag pipeline tracking the datapath latency
  logic [COMP_LAT-1:0] tag_vld;
  logic [COMP_LAT-1:0] tag_id;
  logic [COMP_LAT:0]   tag_vld_sh_c;
  logic [COMP_LAT:0]   tag_id_sh_c;

  logic [DATA_W-1:0]   comp_a_q;
  logic [DATA_W-1:0]   comp_b_q;
  logic [DATA_W-1:0]   comp_c_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                drained_q;

`ifdef SIMPLE_COMP_ARB_RR_EN
  // Requester favoured on the next contention
  logic                rr_ptr;
`endif

  // Grant: only in RUN, and a same-edge drain blocks acceptance
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!rst && (state == ST_RUN) && !bus.drain) begin
`ifdef SIMPLE_COMP_ARB_RR_EN
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_c = !rr_ptr;
        grant1_c = rr_ptr;
      end else begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid;
      end
`else
      grant0_c = bus.req0_valid;
      grant1_c = bus.req1_valid && !bus.req0_valid;
`endif
    end
  end

  // Bit COMP_LAT of the shifted view is the tag leaving the pipeline
  assign tag_vld_sh_c = {tag_vld, iss_vld};
  assign tag_id_sh_c  = {tag_id, iss_id};
  assign pipe_empty_c = !iss_vld && (tag_vld == '0);

  // Datapath issue, tag tracking, response capture and drain FSM
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= ST_RUN;
      iss_vld     <= 1'b0;
      iss_id      <= 1'b0;
      tag_vld     <= '0;
      tag_id      <= '0;
      comp_a_q    <= '0;
      comp_b_q    <= '0;
      comp_c_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      drained_q   <= 1'b0;
`ifdef SIMPLE_COMP_ARB_RR_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      iss_vld <= grant0_c || grant1_c;
      iss_id  <= grant1_c;

      // Operands live for exactly one cycle; zero when nothing issues
      if (grant0_c) begin
        comp_a_q <= bus.req0_a;
        comp_b_q <= bus.req0_b;
        comp_c_q <= bus.req0_c;
      end else if (grant1_c) begin
        comp_a_q <= bus.req1_a;
        comp_b_q <= bus.req1_b;
        comp_c_q <= bus.req1_c;
      end else begin
        comp_a_q <= '0;
        comp_b_q <= '0;
        comp_c_q <= '0;
      end

      tag_vld <= tag_vld_sh_c[COMP_LAT-1:0];
      tag_id  <= tag_id_sh_c[COMP_LAT-1:0];

      rsp_valid_q <= tag_vld_sh_c[COMP_LAT];
      if (tag_vld_sh_c[COMP_LAT]) begin
        rsp_id_q   <= tag_id_sh_c[COMP_LAT];
        rsp_data_q <= bus.comp_d_in;
      end

`ifdef SIMPLE_COMP_ARB_RR_EN
      if (grant0_c) begin
        rr_ptr <= 1'b1;
      end else if (grant1_c) begin
        rr_ptr <= 1'b0;
      end
`endif

      case (state)
        ST_RUN: begin
          drained_q <= 1'b0;
          if (bus.drain) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!bus.drain) begin
            state     <= ST_RUN;
            drained_q <= 1'b0;
          end else if (pipe_empty_c) begin
            state     <= ST_DRAINED;
            drained_q <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!bus.drain) begin
            state     <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.comp_a     = comp_a_q;
  assign bus.comp_b     = comp_b_q;
  assign bus.comp_c     = comp_c_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.drained    = drained_q;
endmodule

// File: doc/simple_comp_arbiter.md
SIMPLE_COMP_ARBITER -- requirements
Module: simple_comp_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  synchronous active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have parameter COMP_LAT, default 2, meaning clock cycles from comp_a/b/c to valid comp_d_in (legal range 1..8).
REQ-004 SHALL have, per requester n in {0,1}: reqn_valid  input  1  request present.
REQ-005 SHALL have reqn_a, reqn_b, reqn_c  input  16 each  operand triple.
REQ-006 SHALL have reqn_ready  output  1  request accepted this cycle.
REQ-007 SHALL have comp_a, comp_b, comp_c  output  16 each  operands to the shared simple_comp datapath.
REQ-008 SHALL have comp_d_in  input  16  datapath result.
REQ-009 SHALL have rsp_valid  output  1, rsp_id  output  1, rsp_data  output  16  result, owning requester, one-cycle pulse, no backpressure.
REQ-010 SHALL have drain  input  1  stop issuing, and drained  output  1  pipeline empty while draining.

Function
REQ-011 SHALL accept a request when reqn_valid and reqn_ready are both high at a rising edge; at most one ready high per cycle; reqn_ready depends only on state and valids.
REQ-012 SHALL arbitrate by policy per REQ-024/025 when both valids are high; a lone valid is granted immediately in RUN.
REQ-013 SHALL register the accepted operands onto comp_a/b/c for exactly the cycle after acceptance, and drive 16'h0000 in cycles with no issue.
REQ-014 SHALL carry a valid bit plus requester ID through a COMP_LAT-deep tag shift register; when the tag emerges, capture comp_d_in into rsp_data.
REQ-015 SHALL assert rsp_valid exactly COMP_LAT+1 cycles after the accepting edge, with rsp_id of the accepted requester; rsp_data 16-bit unmodified.
REQ-016 SHALL sustain one issue per cycle; back-to-back responses preserve issue order.
REQ-017 SHALL run FSM RUN -> DRAIN when drain high; DRAIN -> DRAINED when tag pipeline empty; DRAINED -> RUN when drain low; DRAIN -> RUN if drain drops early.
REQ-018 SHALL deassert all reqn_ready in DRAIN and DRAINED; in-flight results still return; drained high only in DRAINED.
REQ-019 SHALL, when drain and a valid arrive on the same edge in RUN, not accept the request (drain takes priority).

Reset
REQ-020 SHALL on rst: state RUN, tag pipeline cleared, round-robin pointer to requester 0.
REQ-021 SHALL hold after reset: reqn_ready 0 during the reset cycle, comp_a/b/c 0, rsp_valid 0, rsp_id 0, rsp_data 0, drained 0.
REQ-022 SHALL discard in-flight results on reset mid-operation: no rsp_valid for any request accepted before reset.
REQ-023 SHALL not require reset of operand inputs; X on inputs while reqn_valid low has no effect.

Configuration
REQ-024 SHALL, with macro SIMPLE_COMP_ARB_RR_EN defined, use round-robin: on contention grant the requester not granted most recently; pointer updates only on an actual grant.
REQ-025 SHALL, without SIMPLE_COMP_ARB_RR_EN, use fixed priority: requester 0 always wins contention (requester 1 may starve).

Verification
REQ-026 SHALL test single issue: COMP_LAT=2, req0 a=b=c=16'h0fff at edge E -> comp_a=16'h0fff in cycle E+1, rsp_valid, rsp_id=0, rsp_data=comp_d_in at E+3.
REQ-027 SHALL test contention, RR_EN defined: both valid 4 cycles -> grants 0,1,0,1, responses in the same order, one per cycle.
REQ-028 SHALL test contention, RR_EN undefined: both valid 4 cycles -> req0_ready high 4 cycles, req1_ready never high.
REQ-029 SHALL test drain: 3 issues then drain=1 -> no ready, 3 responses returned, drained=1 the cycle after the last rsp_valid; drain=0 -> RUN, req 16'h0666 accepted.
REQ-030 SHALL test reset mid-flight: rst pulsed 1 cycle after two acceptances -> no rsp_valid in the following COMP_LAT+2 cycles, all outputs 0.
